// File: rtl/input_conditioner.sv
// Board input front end: synchronises switches and buttons, debounces each button
// and turns every debounced press into one registered, strictly one-hot load pulse.
module input_conditioner #(
  parameter int N_SW            = 6,
  parameter int N_B             = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_B-1:0]  i_buttons,
  input  logic [N_SW-1:0] i_SWs,
  output logic [N_B-1:0]  o_buttons,
  output logic [N_SW-1:0] o_SWs
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_B-1:0]  btn_meta_q, btn_sync_q;
  logic [N_SW-1:0] sw_meta_q, sw_sync_q;
  logic [N_B-1:0]  press;
  logic [N_B-1:0]  pending_q, pending_d;
  logic [N_B-1:0]  issue_oh;
  logic [N_B-1:0]  pulse_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= i_buttons;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= i_SWs;
      sw_sync_q  <= sw_meta_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_B; gi++) begin : g_debounce
      logic             stable_q, stable_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // A disagreement shorter than DEBOUNCE_CYCLES loses its whole count.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (btn_sync_q[gi] != stable_q) begin
          if (cnt_q == CNT_MAX) begin
            stable_d = btn_sync_q[gi];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      assign press[gi] = stable_d & ~stable_q;
    end
  endgenerate

  always_comb begin
    issue_oh = '0;
    for (int i = N_B - 1; i >= 0; i--) begin
      if (pending_q[i] && (issue_oh == '0)) begin
        issue_oh[i] = 1'b1;
      end
    end
  end

  // OR-ing the press after the clear lets a new press win over its own issue.
  assign pending_d = (pending_q & ~issue_oh) | press;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      pulse_q   <= '0;
    end else begin
      pending_q <= pending_d;
      pulse_q   <= issue_oh;
    end
  end

  assign o_buttons = pulse_q;
  assign o_SWs     = sw_sync_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a cycle-level reference model pushes the
// expected outputs, a monitor pops and compares them, plus directed pulse-timing checks.
module tb_input_conditioner;

  localparam int D   = 4;
  localparam int NB  = 3;
  localparam int NSW = 6;

  logic           clk;
  logic           rst_n;
  logic [NB-1:0]  btn_i;
  logic [NSW-1:0] sw_i;
  logic [NB-1:0]  o_buttons;
  logic [NSW-1:0] o_SWs;

  input_conditioner #(
    .N_SW           (NSW),
    .N_B            (NB),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock    (clk),
    .reset    (rst_n),
    .i_buttons(btn_i),
    .i_SWs    (sw_i),
    .o_buttons(o_buttons),
    .o_SWs    (o_SWs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0]  b;
    logic [NSW-1:0] sw;
  } exp_t;

  typedef struct {
    int             en;
    logic [NB-1:0]  b;
    logic [NSW-1:0] sw;
  } pulse_t;

  exp_t   exp_q[$];
  pulse_t plog[$];
  int     edge_n = 0;
  int     tests  = 0;
  int     fails  = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Reference model: ideal two-stage delay, a D-wide window of synchronised samples
  // that must all disagree with the stable level, and a priority queue of presses.
  initial begin : model
    logic [NB-1:0]  b_s1, b_s2, old_s2, stab, pend, press, out;
    logic [NSW-1:0] sw_s1, exp_sw;
    logic [D-1:0]   hist [NB];
    b_s1 = '0; b_s2 = '0; stab = '0; pend = '0; sw_s1 = '0;
    for (int b = 0; b < NB; b++) hist[b] = '0;
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rst_n) begin
        b_s1 = '0; b_s2 = '0; stab = '0; pend = '0; sw_s1 = '0;
        for (int b = 0; b < NB; b++) hist[b] = '0;
        exp_q.push_back('{b: '0, sw: '0});
      end else begin
        exp_sw = sw_s1;
        sw_s1  = sw_i;
        old_s2 = b_s2;
        b_s2   = b_s1;
        b_s1   = btn_i;
        press  = '0;
        for (int b = 0; b < NB; b++) begin
          hist[b] = {hist[b][D-2:0], old_s2[b]};
          if (hist[b] == {D{~stab[b]}}) begin
            stab[b] = ~stab[b];
            press[b] = stab[b];
          end
        end
        out = '0;
        for (int b = NB - 1; b >= 0; b--) begin
          if (pend[b] && out == '0) out[b] = 1'b1;
        end
        pend = (pend & ~out) | press;
        exp_q.push_back('{b: out, sw: exp_sw});
      end
    end
  end

  initial begin : monitor
    exp_t   e;
    pulse_t p;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_btn", int'(o_buttons), int'(e.b));
        chk("sb_sw", int'(o_SWs), int'(e.sw));
        chk("onehot", int'($countones(o_buttons) <= 1), 1);
        if (o_buttons != '0) begin
          p.en = edge_n; p.b = o_buttons; p.sw = o_SWs;
          plog.push_back(p);
          $display("[TB] edge %0d pulse %b sw %h", edge_n, o_buttons, o_SWs);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_log(input string name, input int n, input int e0, input int b0,
                           input int e1, input int b1);
    chk({name, "_count"}, plog.size(), n);
    if (n > 0 && plog.size() > 0) begin
      chk({name, "_edge0"}, plog[0].en, e0);
      chk({name, "_val0"}, int'(plog[0].b), b0);
    end
    if (n > 1 && plog.size() > 1) begin
      chk({name, "_edge1"}, plog[1].en, e1);
      chk({name, "_val1"}, int'(plog[1].b), b1);
    end
    $display("[TB] scenario %s: %0d pulse(s)", name, plog.size());
  endtask

  int r;
  int nrand;

  initial begin
    rst_n = 1'b0;
    btn_i = '0;
    sw_i  = '0;
    tick(1);
    btn_i = 3'b111;
    sw_i  = 6'h3F;
    tick(3);
    chk("rst_btn", int'(o_buttons), 0);
    chk("rst_sw", int'(o_SWs), 0);
    btn_i = '0;
    sw_i  = '0;
    tick(1);
    rst_n = 1'b1;
    tick(10);

    plog.delete();
    r = edge_n + 1;
    btn_i = 3'b100;
    tick(30);
    btn_i = '0;
    tick(20);
    check_log("clean", 1, r + 6, 4, 0, 0);

    plog.delete();
    repeat (4) begin
      btn_i = 3'b010; tick(3);
      btn_i = 3'b000; tick(1);
    end
    r = edge_n + 1;
    btn_i = 3'b010;
    tick(20);
    btn_i = '0;
    tick(20);
    check_log("bounce", 1, r + 6, 2, 0, 0);

    plog.delete();
    r = edge_n + 1;
    btn_i = 3'b101;
    tick(20);
    btn_i = '0;
    tick(20);
    check_log("simul", 2, r + 6, 4, r + 7, 1);

    plog.delete();
    r = edge_n + 1;
    btn_i = 3'b001;
    tick(1);
    btn_i = 3'b101;
    tick(20);
    btn_i = '0;
    tick(20);
    check_log("stagger", 2, r + 6, 1, r + 7, 4);

    plog.delete();
    r = edge_n + 1;
    btn_i = 3'b010;
    sw_i  = 6'h15;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("rstmid_btn", int'(o_buttons), 0);
    chk("rstmid_sw", int'(o_SWs), 0);
    tick(1);
    rst_n = 1'b1;
    tick(20);
    btn_i = '0;
    tick(20);
    check_log("rstmid", 1, r + 10, 2, 0, 0);

    plog.delete();
    r = edge_n + 1;
    sw_i  = 6'h2A;
    btn_i = 3'b001;
    tick(2);
    chk("sw_latency", int'(o_SWs), 'h2A);
    tick(20);
    check_log("swpath", 1, r + 6, 1, 0, 0);
    if (plog.size() > 0) chk("sw_at_pulse", int'(plog[0].sw), 'h2A);
    btn_i = '0;
    tick(20);

    plog.delete();
    repeat (3000) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(11) == 0) btn_i[b] = ~btn_i[b];
      end
      if ($urandom_range(7) == 0) sw_i = NSW'($urandom);
      if ($urandom_range(499) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(2) == 0) rst_n = 1'b1;
      tick(1);
    end
    rst_n = 1'b1;
    btn_i = '0;
    tick(30);
    nrand = plog.size();
    $display("[TB] random phase: %0d pulses", nrand);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage that conditions the raw board inputs (push-buttons and slide switches) before they reach the ALU top level's operand/opcode load logic. Each button is synchronised, debounced and converted into a single-cycle, strictly one-hot load pulse. Simultaneous presses are queued so that each is issued separately. Switches are synchronised and forwarded so that the downstream registers never sample a metastable or bouncing value.

## Interface

- N_SW, 6, number of slide switches (operand/opcode width)
- N_B, 3, number of push-buttons (load strobes; bit 2 = A, bit 1 = B, bit 0 = OP)
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised button must differ from its stable state before the state changes; must be >= 1
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived)

- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- i_buttons  input  N_B  raw asynchronous button levels, 1 = pressed
- i_SWs  input  N_SW  raw asynchronous switch levels
- o_buttons  output  N_B  one-hot load pulses, one cycle wide, registered
- o_SWs  output  N_SW  synchronised switch levels

## Operation

- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset (reset = 0): clears every flop.
  - Synchronisers, stable states, counters and the pending register go to 0.
  - o_buttons = 0 and o_SWs = 0 while reset is low.
- Synchronisers: two flop stages on every i_buttons and i_SWs bit.
  - o_SWs is driven directly from the second switch stage.
- Debounce: one independent unit per button, each with a stable state bit and a counter.
  - If the synchronised value equals the stable state, the counter is cleared to 0.
  - If it differs and the counter is less than DEBOUNCE_CYCLES-1, the counter increments.
  - If it differs and the counter equals DEBOUNCE_CYCLES-1, the stable state takes the synchronised value and the counter is cleared.
  - Net effect: the input must differ for DEBOUNCE_CYCLES consecutive cycles. Any shorter glitch is discarded and its count is lost.
- Press detection: a 0->1 transition of a stable state sets that button's pending bit on the same edge.
  - A 1->0 transition (release) has no effect.
- Issue stage: on each edge, if any pending bit is set:
  - o_buttons takes the one-hot code of the highest-index pending bit (priority A > B > OP).
  - That pending bit is cleared.
  - If no pending bit is set, o_buttons takes 0.
- Set/clear collision: if a pending bit is cleared by issue and set by a new press on the same edge, the set wins.
- Invariants:
  - o_buttons is always 0 or exactly one-hot.
  - Every debounced press produces exactly one pulse.
  - Presses are never merged or dropped, except a second press of the same button while its pending bit is still set, which is absorbed.
- Reset mid-operation: all in-flight counts and pending presses are discarded.
  - A button still held when reset is released is treated as a new press and produces one pulse after the full latency.

## Timing

- Edge k is the first rising edge at which a raw button level is sampled high, with the level held from then on.
  - Synchroniser output changes at edge k+1.
  - Stable state flips and the pending bit sets at edge k+1+DEBOUNCE_CYCLES.
  - o_buttons is one-hot after edge k+2+DEBOUNCE_CYCLES for exactly one cycle (no other press pending).
- Each additional queued press adds one cycle of delay. N simultaneous presses appear on N consecutive cycles in priority order.
- Switch path: i_SWs sampled at edge k appears on o_SWs after edge k+1 (2-cycle latency, no debounce).
- Downstream the load pulse and o_SWs are sampled on the same edge. Switches must be stable for at least 2 cycles before the pulse, which is always true for manual operation.
- Back-to-back pulses for the same button are impossible: they are separated by at least a release plus a re-press, i.e. at least 2*DEBOUNCE_CYCLES cycles.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4.

- Clean press: i_buttons=3'b100 raised at edge 10 and held 30 cycles -> o_buttons=3'b100 after edge 16 only; 0 on every other cycle; release produces no pulse.
- Bounce rejection: button 1 toggles high 3 cycles / low 1 cycle four times, then holds high -> no pulse during bouncing; single 3'b010 pulse 6 edges after the final rising sample.
- Simultaneous press: 3'b101 applied at edge 10 -> 3'b100 after edge 16 and 3'b001 after edge 17; never 3'b101.
- Staggered press: button 0 at edge 10, button 2 at edge 11 -> 3'b001 after edge 16, 3'b100 after edge 17; exactly two pulses.
- Reset mid-debounce: button 1 raised at edge 10; reset low for cycles 12-13 while held -> o_buttons=0 and o_SWs=0 during reset; exactly one 3'b010 pulse 6 edges after the first post-reset edge.
- Switch path: i_SWs=6'h2A at edge 5 -> o_SWs=6'h2A after edge 6. With a press of button 0 held from edge 5, o_SWs=6'h2A is present on the cycle o_buttons=3'b001.
